// File: rtl/life_engine.sv
// life_engine: X*Y Game of Life board (B3/S23) updated serially, one cell per
// clock, by an IDLE/CALC/COMMIT controller. Supports toroidal or dead-border
// edges, run/step control, a generation counter, board clear and cursor
// editing that is locked out while a generation is being computed.
module life_engine #(
  parameter int X     = 8,
  parameter int Y     = 8,
  parameter int LOG2X = 3,
  parameter int LOG2Y = 3,
  parameter int GEN_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               step,
  input  logic               clear,
  input  logic               wrap,
  input  logic               key_flip,
  input  logic               key_up,
  input  logic               key_down,
  input  logic               key_left,
  input  logic               key_right,
  input  logic [LOG2Y-1:0]   row_sel,
  output logic [X-1:0]       row,
  output logic [LOG2X-1:0]   cursor_x,
  output logic [LOG2Y-1:0]   cursor_y,
  output logic               busy,
  output logic               gen_done,
  output logic [GEN_W-1:0]   gen_count
);

  localparam int N     = X * Y;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [LOG2X-1:0] XMAX     = LOG2X'(X - 1);
  localparam logic [LOG2Y-1:0] YMAX     = LOG2Y'(Y - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_COMMIT} state_t;

  state_t              r_state;
  logic [N-1:0]        r_cur;
  logic [N-1:0]        r_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [LOG2X-1:0]    r_calc_x;
  logic [LOG2Y-1:0]    r_calc_y;
  logic [LOG2X-1:0]    r_cursor_x;
  logic [LOG2Y-1:0]    r_cursor_y;
  logic                r_busy;
  logic                r_gen_done;
  logic [GEN_W-1:0]    r_gen_count;

  logic [3:0]          w_sum;
  logic                w_live;
  logic                w_new;
  logic [N-1:0]        w_flip_mask;
  logic [N-1:0]        w_row_shift;

  // Value of the cell at (cx,cy); coordinates one step off the board either
  // wrap around (toroidal) or read as dead.
  function automatic logic f_cell(input logic [N-1:0] b, input int cx,
                                  input int cy, input logic wr);
    int           nx;
    int           ny;
    int           idx;
    logic         ok;
    logic [N-1:0] sh;
    nx = cx;
    ny = cy;
    ok = 1'b1;
    if (nx < 0) begin
      if (wr) nx = X - 1; else ok = 1'b0;
    end else if (nx >= X) begin
      if (wr) nx = 0; else ok = 1'b0;
    end
    if (ny < 0) begin
      if (wr) ny = Y - 1; else ok = 1'b0;
    end else if (ny >= Y) begin
      if (wr) ny = 0; else ok = 1'b0;
    end
    idx = ok ? (ny * X + nx) : 0;
    sh  = b >> idx;
    return ok & sh[0];
  endfunction

  // B3/S23: birth on exactly 3, survival on 2 or 3.
  function automatic logic f_rule(input logic live, input logic [3:0] sum);
    return (sum == 4'd3) | (live & (sum == 4'd2));
  endfunction

  // Neighbour count and next state of the cell currently being evaluated.
  always_comb begin
    w_sum = 4'd0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        if (dx != 0 || dy != 0)
          w_sum = w_sum + {3'b000, f_cell(r_cur, int'(r_calc_x) + dx,
                                          int'(r_calc_y) + dy, wrap)};
      end
    end
    w_live = f_cell(r_cur, int'(r_calc_x), int'(r_calc_y), 1'b0);
    w_new  = f_rule(w_live, w_sum);
  end

  // One-hot mask selecting the cell under the cursor.
  always_comb begin
    w_flip_mask = {{(N-1){1'b0}}, 1'b1} << (int'(r_cursor_y) * X + int'(r_cursor_x));
  end

  // Display readout of one board row; rows past the board read as empty.
  always_comb begin
    w_row_shift = r_cur >> (int'(row_sel) * X);
    row         = (int'(row_sel) < Y) ? w_row_shift[X-1:0] : '0;
  end

  // Generation controller: edits in IDLE, serial evaluation in CALC, board swap in COMMIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cur       <= '0;
      r_nxt       <= '0;
      r_cnt       <= '0;
      r_calc_x    <= '0;
      r_calc_y    <= '0;
      r_busy      <= 1'b0;
      r_gen_done  <= 1'b0;
      r_gen_count <= '0;
    end else begin
      r_gen_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (clear) begin
            r_cur <= '0;
          end else begin
            // A flip coinciding with a start lands before CALC reads the board.
            if (key_flip)
              r_cur <= r_cur ^ w_flip_mask;
            if (run || step) begin
              r_state  <= S_CALC;
              r_cnt    <= '0;
              r_calc_x <= '0;
              r_calc_y <= '0;
              r_busy   <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_nxt[r_cnt] <= w_new;
          if (r_cnt == CNT_LAST) begin
            r_state <= S_COMMIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_calc_x == XMAX) begin
              r_calc_x <= '0;
              r_calc_y <= r_calc_y + 1'b1;
            end else begin
              r_calc_x <= r_calc_x + 1'b1;
            end
          end
        end
        S_COMMIT: begin
          r_cur       <= r_nxt;
          r_gen_count <= r_gen_count + 1'b1;
          r_gen_done  <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Cursor movement, active in every state, wrapping on both axes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cursor_x <= '0;
      r_cursor_y <= '0;
    end else begin
      if (key_left && !key_right)
        r_cursor_x <= (r_cursor_x == '0) ? XMAX : r_cursor_x - 1'b1;
      else if (key_right && !key_left)
        r_cursor_x <= (r_cursor_x == XMAX) ? '0 : r_cursor_x + 1'b1;
      if (key_up && !key_down)
        r_cursor_y <= (r_cursor_y == '0) ? YMAX : r_cursor_y - 1'b1;
      else if (key_down && !key_up)
        r_cursor_y <= (r_cursor_y == YMAX) ? '0 : r_cursor_y + 1'b1;
    end
  end

  assign cursor_x  = r_cursor_x;
  assign cursor_y  = r_cursor_y;
  assign busy      = r_busy;
  assign gen_done  = r_gen_done;
  assign gen_count = r_gen_count;

endmodule

// File: tb/tb_life_engine.sv
// Testbench for life_engine: an 8x8 instance exercised through its editing,
// stepping and run controls against a cell-array model of the board, plus an
// 8x6 instance with a 2-bit generation counter.
`timescale 1ns/1ps
module tb_life_engine;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       reset;
  logic       run, step, clear, wrap;
  logic       kf, ku, kd, kl, kr;
  logic [2:0] row_sel;
  logic [7:0] row;
  logic [2:0] cx, cy;
  logic       busy, gd;
  logic [15:0] gc;

  logic       run2, ku2, kf2;
  logic [2:0] row_sel2;
  logic [7:0] row2;
  logic [2:0] cx2, cy2;
  logic       busy2, gd2;
  logic [1:0] gc2;

  life_engine #(.X(8), .Y(8), .LOG2X(3), .LOG2Y(3), .GEN_W(16)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .clear(clear), .wrap(wrap),
    .key_flip(kf), .key_up(ku), .key_down(kd), .key_left(kl), .key_right(kr),
    .row_sel(row_sel), .row(row), .cursor_x(cx), .cursor_y(cy),
    .busy(busy), .gen_done(gd), .gen_count(gc));

  life_engine #(.X(8), .Y(6), .LOG2X(3), .LOG2Y(3), .GEN_W(2)) dut2 (
    .clk(clk), .reset(reset), .run(run2), .step(1'b0), .clear(1'b0), .wrap(1'b1),
    .key_flip(kf2), .key_up(ku2), .key_down(1'b0), .key_left(1'b0), .key_right(1'b0),
    .row_sel(row_sel2), .row(row2), .cursor_x(cx2), .cursor_y(cy2),
    .busy(busy2), .gen_done(gd2), .gen_count(gc2));

  int checks = 0;
  int errors = 0;

  // Reference model: board as a flat cell array, cursor and generation count.
  bit mb[64];
  int m_cx, m_cy, m_gen;
  int cells_q[$];

  function automatic void m_reset();
    foreach (mb[i]) mb[i] = 1'b0;
    m_cx = 0; m_cy = 0; m_gen = 0;
  endfunction

  function automatic void m_step(input bit w);
    bit t[64];
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        int s;
        s = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            int nx, ny;
            if (dx == 0 && dy == 0) continue;
            nx = x + dx; ny = y + dy;
            if (w) begin
              nx = (nx + 8) % 8; ny = (ny + 8) % 8;
              s += mb[ny*8+nx];
            end else if (nx >= 0 && nx < 8 && ny >= 0 && ny < 8) begin
              s += mb[ny*8+nx];
            end
          end
        end
        t[y*8+x] = (s == 3) || (mb[y*8+x] && s == 2);
      end
    end
    mb = t;
  endfunction

  function automatic logic [7:0] m_row(input int r);
    logic [7:0] v;
    for (int x = 0; x < 8; x++) v[x] = mb[r*8+x];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_board(input string tag);
    for (int r = 0; r < 8; r++) begin
      row_sel = 3'(r);
      #1;
      checks++;
      if (row !== m_row(r)) begin
        errors++;
        $display("FAIL %s row %0d: got %h expected %h", tag, r, row, m_row(r));
      end
    end
    row_sel = 3'd0;
  endtask

  // One cycle of key pulses while IDLE; the flip uses the pre-move cursor.
  task automatic press(input bit f, input bit u, input bit d, input bit l, input bit r);
    kf = f; ku = u; kd = d; kl = l; kr = r;
    tick();
    kf = 0; ku = 0; kd = 0; kl = 0; kr = 0;
    if (f) mb[m_cy*8+m_cx] = ~mb[m_cy*8+m_cx];
    if (l && !r) m_cx = (m_cx + 7) % 8; else if (r && !l) m_cx = (m_cx + 1) % 8;
    if (u && !d) m_cy = (m_cy + 7) % 8; else if (d && !u) m_cy = (m_cy + 1) % 8;
    checks++;
    if (int'(cx) != m_cx || int'(cy) != m_cy) begin
      errors++;
      $display("FAIL cursor: got (%0d,%0d) expected (%0d,%0d)", cx, cy, m_cx, m_cy);
    end
  endtask

  task automatic goto_cell(input int x, input int y);
    for (int i = 0; i < 8 && m_cx != x; i++) press(0, 0, 0, 0, 1);
    for (int i = 0; i < 8 && m_cy != y; i++) press(0, 0, 1, 0, 0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    foreach (mb[i]) mb[i] = 1'b0;
  endtask

  task automatic load_q();
    do_clear();
    foreach (cells_q[i]) begin
      goto_cell(cells_q[i] % 8, cells_q[i] / 8);
      press(1, 0, 0, 0, 0);
    end
  endtask

  // Single step (optionally with a coincident flip) and full timing check.
  task automatic do_step(input bit w, input bit with_flip, input string tag);
    int n, nb;
    wrap = w;
    kf = with_flip;
    step = 1'b1;
    tick();
    step = 1'b0;
    kf = 1'b0;
    if (with_flip) mb[m_cy*8+m_cx] = ~mb[m_cy*8+m_cx];
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL %s busy_rise: got %b expected 1", tag, busy);
    end
    n = 0; nb = 0;
    while (gd !== 1'b1 && n < 200) begin
      if (busy === 1'b1) nb++;
      tick();
      n++;
    end
    checks++;
    if (n != 65) begin
      errors++; $display("FAIL %s gen_done_latency: got %0d expected 65", tag, n);
    end
    checks++;
    if (nb != 65) begin
      errors++; $display("FAIL %s busy_cycles: got %0d expected 65", tag, nb);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL %s busy_fall: got %b expected 0", tag, busy);
    end
    m_step(w);
    m_gen++;
    checks++;
    if (gc !== 16'(m_gen)) begin
      errors++; $display("FAIL %s gen_count: got %0d expected %0d", tag, gc, m_gen);
    end
    tick();
    checks++;
    if (gd !== 1'b0) begin
      errors++; $display("FAIL %s gen_done_width: got %b expected 0", tag, gd);
    end
    check_board(tag);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    m_reset();
    checks++;
    if (busy !== 1'b0 || gd !== 1'b0 || gc !== 16'd0 || cx !== 3'd0 || cy !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b cnt=%0d cur=(%0d,%0d) expected all 0",
               busy, gd, gc, cx, cy);
    end
    check_board("reset_board");
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_cursor();
    press(0, 0, 0, 1, 0);
    checks++;
    if (cx !== 3'd7) begin errors++; $display("FAIL left_wrap: got %0d expected 7", cx); end
    press(0, 1, 0, 0, 0);
    checks++;
    if (cy !== 3'd7) begin errors++; $display("FAIL up_wrap: got %0d expected 7", cy); end
    press(1, 0, 0, 0, 0);
    row_sel = 3'd7;
    #1;
    checks++;
    if (row !== 8'h80) begin errors++; $display("FAIL flip_corner: got %h expected 80", row); end
    do_clear();
    row_sel = 3'd7;
    #1;
    checks++;
    if (row !== 8'h00) begin errors++; $display("FAIL clear_row: got %h expected 00", row); end
    press(0, 1, 1, 1, 1);
    press(1, 0, 1, 0, 1);
    press(0, 0, 1, 0, 0);
    check_board("cursor_edit");
  endtask

  task automatic test_blinker();
    cells_q = '{26, 27, 28};
    load_q();
    do_step(1'b1, 1'b0, "blinker1");
    for (int r = 0; r < 8; r++) begin
      logic [7:0] e;
      e = (r >= 2 && r <= 4) ? 8'h08 : 8'h00;
      row_sel = 3'(r);
      #1;
      checks++;
      if (row !== e) begin
        errors++; $display("FAIL blinker_vertical row %0d: got %h expected %h", r, row, e);
      end
    end
    do_step(1'b1, 1'b0, "blinker2");
    row_sel = 3'd3;
    #1;
    checks++;
    if (row !== 8'h1C || gc !== 16'd2) begin
      errors++; $display("FAIL blinker_back: got row %h gen %0d expected 1c gen 2", row, gc);
    end
    row_sel = 3'd0;
  endtask

  task automatic test_corner();
    cells_q = '{0, 7, 56, 63};
    load_q();
    do_step(1'b1, 1'b0, "corner_wrap");
    row_sel = 3'd0; #1;
    checks++;
    if (row !== 8'h81) begin errors++; $display("FAIL corner_wrap_row0: got %h expected 81", row); end
    row_sel = 3'd7; #1;
    checks++;
    if (row !== 8'h81) begin errors++; $display("FAIL corner_wrap_row7: got %h expected 81", row); end
    load_q();
    do_step(1'b0, 1'b0, "corner_dead");
    row_sel = 3'd0; #1;
    checks++;
    if (row !== 8'h00) begin errors++; $display("FAIL corner_dead_row0: got %h expected 00", row); end
  endtask

  task automatic test_flip_start();
    do_clear();
    for (int i = 0; i < 10; i++) goto_cell(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    cells_q = '{};
    press(1, 0, 0, 0, 1);
    press(1, 0, 0, 0, 1);
    do_step(1'b1, 1'b1, "flip_with_start");
  endtask

  task automatic test_random_cursor();
    for (int i = 0; i < 40; i++) begin
      logic [4:0] k;
      k = 5'($urandom);
      press(k[0], k[1], k[2], k[3], k[4]);
    end
    check_board("random_cursor");
  endtask

  task automatic test_random_gens();
    for (int it = 0; it < 4; it++) begin
      do_clear();
      for (int j = 0; j < 14; j++) begin
        goto_cell(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        press(1, 0, 0, 0, 0);
      end
      do_step(1'($urandom), 1'b0, "random_gen");
    end
  endtask

  task automatic test_run_lockout();
    int cyc, ndone;
    int t[3];
    bit w;
    do_clear();
    for (int j = 0; j < 16; j++) begin
      goto_cell(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      press(1, 0, 0, 0, 0);
    end
    w = 1'($urandom);
    wrap = w;
    run = 1'b1;
    cyc = 0; ndone = 0;
    while (ndone < 3 && cyc < 400) begin
      kf    = (cyc == 10);
      clear = (cyc == 20);
      step  = (cyc == 80);
      tick();
      cyc++;
      kf = 1'b0; clear = 1'b0; step = 1'b0;
      if (gd === 1'b1) begin
        t[ndone] = cyc;
        ndone++;
        if (ndone == 3) run = 1'b0;
      end
    end
    run = 1'b0;
    checks++;
    if (ndone != 3) begin
      errors++; $display("FAIL run_timeout: got %0d pulses expected 3", ndone);
    end else begin
      checks++;
      if (t[0] != 66) begin errors++; $display("FAIL run_first: got %0d expected 66", t[0]); end
      checks++;
      if (t[1] - t[0] != 66) begin errors++; $display("FAIL run_period1: got %0d expected 66", t[1]-t[0]); end
      checks++;
      if (t[2] - t[1] != 66) begin errors++; $display("FAIL run_period2: got %0d expected 66", t[2]-t[1]); end
    end
    for (int g = 0; g < 3; g++) m_step(w);
    m_gen += 3;
    checks++;
    if (gc !== 16'(m_gen)) begin
      errors++; $display("FAIL run_gen_count: got %0d expected %0d", gc, m_gen);
    end
    repeat (4) tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL run_stop: got busy %b expected 0", busy); end
    check_board("run_lockout");
  endtask

  task automatic test_small_board();
    ku2 = 1'b1; tick(); ku2 = 1'b0;
    checks++;
    if (cy2 !== 3'd5) begin errors++; $display("FAIL y6_up_wrap: got %0d expected 5", cy2); end
    kf2 = 1'b1; tick(); kf2 = 1'b0;
    row_sel2 = 3'd5; #1;
    checks++;
    if (row2 !== 8'h01) begin errors++; $display("FAIL y6_row5: got %h expected 01", row2); end
    row_sel2 = 3'd7; #1;
    checks++;
    if (row2 !== 8'h00) begin errors++; $display("FAIL y6_row7: got %h expected 00", row2); end
    row_sel2 = 3'd6; #1;
    checks++;
    if (row2 !== 8'h00) begin errors++; $display("FAIL y6_row6: got %h expected 00", row2); end
  endtask

  task automatic test_counter_wrap();
    int k, n, last;
    run2 = 1'b1;
    k = 0; n = 0; last = 0;
    while (k < 5 && n < 500) begin
      tick();
      n++;
      if (gd2 === 1'b1) begin
        checks++;
        if (gc2 !== 2'((k + 1) % 4)) begin
          errors++; $display("FAIL counter_wrap %0d: got %0d expected %0d", k, gc2, (k+1)%4);
        end
        if (k > 0) begin
          checks++;
          if (n - last != 50) begin
            errors++; $display("FAIL y6_period: got %0d expected 50", n - last);
          end
        end
        last = n;
        k++;
        if (k == 5) run2 = 1'b0;
      end
    end
    run2 = 1'b0;
    checks++;
    if (k != 5) begin errors++; $display("FAIL counter_timeout: got %0d pulses expected 5", k); end
  endtask

  task automatic test_reset_mid_calc();
    int seen;
    cells_q = '{26, 27, 28};
    load_q();
    wrap = 1'b1;
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (29) tick();
    #3;
    reset = 1'b0;
    #1;
    m_reset();
    checks++;
    if (busy !== 1'b0 || gc !== 16'd0 || gd !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got busy=%b cnt=%0d done=%b expected 0 0 0", busy, gc, gd);
    end
    check_board("mid_reset");
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (gd === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL mid_reset_no_done: got %0d active cycles expected 0", seen);
    end
    check_board("after_reset");
  endtask

  initial begin
    reset = 1'b1;
    run = 0; step = 0; clear = 0; wrap = 1;
    kf = 0; ku = 0; kd = 0; kl = 0; kr = 0;
    row_sel = 0;
    run2 = 0; ku2 = 0; kf2 = 0; row_sel2 = 0;
    m_reset();
    #5;
    test_reset();
    test_cursor();
    test_blinker();
    test_corner();
    test_flip_start();
    test_random_cursor();
    test_random_gens();
    test_run_lockout();
    test_small_board();
    test_counter_wrap();
    test_reset_mid_calc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/life_engine.md
# life_engine

Parametrised Game of Life generation engine: holds an X×Y board and computes each new generation serially, one cell per clock, under a small control state machine. Unlike the fixed 8×8 serial-pipe engine, it adds:
- runtime selection of toroidal or dead-border edges;
- run/step/pause control with a generation counter;
- synchronous board clear;
- cursor editing that is locked out while a generation is computing.

It sits between the keypad/debounce logic and the row-scanning display driver.

## Interface
- X, 8, board width in cells (≥3)
- Y, 8, board height in cells (≥3)
- LOG2X, 3, width of cursor_x (2^LOG2X ≥ X)
- LOG2Y, 3, width of cursor_y and row_sel (2^LOG2Y ≥ Y)
- GEN_W, 16, generation counter width

Ports:
- clk  in  1  single system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; forces every register to its reset value
- run  in  1  level; while high, start a new generation whenever IDLE
- step  in  1  one-cycle pulse; start exactly one generation if IDLE
- clear  in  1  one-cycle pulse; zero the board if IDLE
- wrap  in  1  1 = toroidal edges, 0 = cells outside the board are dead; sampled every CALC cycle
- key_flip, key_up, key_down, key_left, key_right  in  1 each  one-cycle pulses from debounce
- row_sel  in  LOG2Y  row index for display readout
- row  out  X  combinational: row[x] = cell(x, row_sel); all zero if row_sel ≥ Y
- cursor_x  out  LOG2X  cursor column
- cursor_y  out  LOG2Y  cursor row
- busy  out  1  high in CALC and COMMIT
- gen_done  out  1  one-cycle pulse; board updated on the edge that raised it
- gen_count  out  GEN_W  generations completed, modulo 2^GEN_W

## Operation
- **Storage.** The board cur[X*Y-1:0] uses index i = y*X + x. A shadow nxt[X*Y-1:0] is written during CALC.
- **Rule (B3/S23).** Neighbour sum is 0..8, held in 4 bits.
  - A live cell survives on 2 or 3 neighbours.
  - A dead cell is born on exactly 3.
- **Edge handling.**
  - wrap=1: x−1 at x=0 is X−1, x+1 at X−1 is 0; y wraps the same way.
  - wrap=0: any neighbour coordinate out of range contributes 0.
- **States.** IDLE, CALC, COMMIT. Reset enters IDLE.
- **IDLE** (priority top to bottom):
  - clear: cur ← 0. No start this cycle, even if run or step is high. Flip is dropped.
  - Otherwise key_flip: cur[cursor] inverted.
  - Otherwise, if run or step: go to CALC with cnt ← 0. Flip and start may coincide; the flip lands first, so CALC sees the flipped board.
- **CALC.** Each cycle nxt[cnt] ← rule(cur, cnt); cnt increments.
  - When cnt = X*Y−1 is evaluated, go to COMMIT.
  - cur is not modified during CALC.
  - key_flip, clear and step are ignored, not queued.
- **COMMIT.** cur ← nxt; gen_count ← gen_count+1 (wraps to 0); gen_done ← 1 for one cycle; go to IDLE.
- **Cursor.** Moves in any state, one cell per key pulse, wrapping at both ends of both axes (left at 0 → X−1; down at Y−1 → 0).
  - key_left and key_right together: no x move. key_up and key_down together: no y move.
  - Cursor moves and a flip in the same cycle: the flip uses the pre-move cursor.
- **Reset values.** cur=0, nxt=0, cursor_x=0, cursor_y=0, gen_count=0, busy=0, gen_done=0, cnt=0, state IDLE.
- **Reset mid-generation.** The asynchronous reset aborts immediately. The board is lost and no gen_done is issued.

## Timing
- Start sampled at edge E0 → CALC from E0. Cells 0..X*Y−1 are evaluated at E1..E(X*Y). COMMIT is entered at E(X*Y).
- cur, gen_count and gen_done update at E(X*Y+1); busy falls at the same edge.
- Latency from start sample to new board: X*Y+1 edges (65 for 8×8).
- run held high: the next start is sampled at E(X*Y+2), giving a period of X*Y+2 cycles (66). Dropping run mid-generation completes the current generation, then stops.
- row is combinational from cur and row_sel. It changes the edge after a COMMIT, flip or clear.
- busy is high for exactly X*Y+1 cycles per generation.

## Test plan
- **Blinker.** 8×8, wrap=1, cells 26,27,28 set, step at E0 → busy high 65 cycles, gen_done at E65, cur has exactly {19,27,35}, gen_count=1. A second step restores {26,27,28}, gen_count=2.
- **Corner block, edge modes.** Cells {0,7,56,63} set.
  - wrap=1, step → board unchanged.
  - Reload, wrap=0, step → board all zero.
- **Run and lockout.**
  - run held 3 generations → gen_done pulses exactly 66 cycles apart.
  - key_flip during CALC → no cell change after COMMIT beyond the rule result.
  - clear during CALC → ignored.
- **Cursor wrap and edit.**
  - From reset, key_left → cursor_x=7.
  - key_up → cursor_y=7.
  - key_flip → row_sel=7 gives row=8'h80.
  - clear → row=0.
  - row_sel=7 with Y=6 → row=0.
- **Reset mid-CALC.** Blinker loaded, step, reset asserted at E30 → immediately busy=0, row=0 for all rows, gen_count=0. No gen_done pulse follows release.
- **Counter wrap.** GEN_W=2, run for 5 generations → gen_count sequence 1,2,3,0,1.
